axi4_lite_write_slave: RTL and testbench
========================================

# axi4_lite_write_slave

AXI4-Lite write-channel slave that terminates the CPU-side write master. It accepts address (AW) and data (W) handshakes in either order or in the same cycle, commits byte-strobed 64-bit writes into an internal word-addressed memory, and returns one write response (B) per transaction. A combinational debug read port exposes memory contents to the core and the bench.

## Interface
- DEPTH, 32: number of 64-bit memory words (power of two, ≥2).
- BASE, 64'h8000_0000: byte address of word 0; must be 8-byte aligned.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- AW_ADDR  in  64  write byte address.
- AW_VALID  in  1  address valid.
- AW_PORT  in  3  protection bits; accepted and ignored.
- AW_READY  out  1  address ready.
- W_DATA  in  64  write data.
- W_STRB  in  8  byte enables; bit i enables W_DATA[8i+7:8i].
- W_VALID  in  1  data valid.
- W_READY  out  1  data ready.
- B_RESP  out  1  response: 0 = OKAY, 1 = SLVERR.
- B_VALID  out  1  response valid.
- B_READY  in  1  response accepted.
- dbg_addr  in  $clog2(DEPTH)  word index for debug read.
- dbg_data  out  64  mem[dbg_addr], combinational.

## Operation
- States: IDLE, WRITE, RESP.
- Holding registers: aw_addr_q/aw_held, w_data_q/w_strb_q/w_held.
- AW_READY = (state==IDLE) & ~aw_held; W_READY = (state==IDLE) & ~w_held. Both combinational from registered state only (no VALID→READY path).
- AW handshake (AW_VALID & AW_READY at edge): capture AW_ADDR, set aw_held. W handshake likewise captures W_DATA/W_STRB, sets w_held. Both may occur on the same edge.
- IDLE → WRITE when, after this edge's captures, aw_held and w_held are both set (including both captured on the same edge).
- WRITE (one cycle): decode aw_addr_q. In range iff BASE ≤ addr < BASE + 8·DEPTH; index = (addr − BASE)[3+:log2(DEPTH)]; addr[2:0] ignored. In range: for each set strobe bit, update that byte of mem[index]; B_RESP ← 0. Out of range: no memory change; B_RESP ← 1. Set B_VALID, clear aw_held/w_held, → RESP.
- W_STRB = 0 in range: no change, OKAY.
- RESP: hold B_VALID and B_RESP stable until B_READY is sampled high; on that edge clear B_VALID, → IDLE. B_READY high before B_VALID is legal and completes on the first B_VALID cycle.
- Only one outstanding transaction; no new AW/W is accepted in WRITE or RESP.
- Subtraction and range compare use 64-bit unsigned arithmetic; addresses below BASE must not wrap into range.

## Timing
- Reset (rst=0, async): state=IDLE, holds cleared, B_VALID=0, B_RESP=0, all mem words=0; thus AW_READY=W_READY=1 while in reset. Handshakes during reset are ignored.
- Reset mid-transaction: pending captured address/data are discarded with no memory write; any asserted B_VALID drops immediately.
- Latency: the later of the two handshakes occurs at edge N; memory updates and B_VALID rises at edge N+1. The earliest B handshake is at edge N+2. The earliest next AW/W acceptance is at edge N+3.
- A memory update is visible on dbg_data immediately after edge N+1.
- Back-to-back throughput: one write per 3 cycles.

## Test plan
- Sequential master order: AW 0x8000_0010 accepted, W 0xDEAD_BEEF_0123_4567 with STRB 0xFF accepted on the next edge, B_READY=1 -> B_VALID one cycle after the W handshake, B_RESP=0, dbg_addr=2 reads 0xDEAD_BEEF_0123_4567.
- Simultaneous AW+W plus byte strobes: mem[0]=0x1111_1111_1111_1111; write to addr 0x8000_0000 with data 0xAABB_CCDD_EEFF_0011 and STRB 0x0F -> mem[0]=0x1111_1111_EEFF_0011. W-before-AW order gives the identical result.
- Out of range: AW 0x8000_0100 (DEPTH=32) and AW 0x7FFF_FFF8 -> B_RESP=1 for both, and all mem words are unchanged.
- Backpressure: B_READY held low for 5 cycles -> B_VALID/B_RESP stay stable, AW_READY=W_READY=0 throughout; transaction completes on the first B_READY=1 edge, readies return the next cycle.
- Reset mid-operation: AW accepted, then rst pulsed low before W -> no write, B_VALID=0; a full transaction after release behaves normally and all other words read 0.

Source files
------------

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write-channel slave: collects AW and W in any order, commits a
// byte-strobed 64-bit write to a local memory, and answers with one B response.
module axi4_lite_write_slave #(
    parameter int unsigned DEPTH = 32,
    parameter logic [63:0] BASE  = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              AW_ADDR,
    input  logic                     AW_VALID,
    input  logic [2:0]               AW_PORT,
    output logic                     AW_READY,
    input  logic [63:0]              W_DATA,
    input  logic [7:0]               W_STRB,
    input  logic                     W_VALID,
    output logic                     W_READY,
    output logic                     B_RESP,
    output logic                     B_VALID,
    input  logic                     B_READY,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [63:0]              dbg_data
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   aw_addr_q;
    logic [63:0]   w_data_q;
    logic [7:0]    w_strb_q;
    logic          aw_held;
    logic          w_held;
    logic          aw_hs;
    logic          w_hs;
    logic [63:0]   offset;
    logic          in_range;
    logic [IW-1:0] index;
    logic          unused_prot;

    assign unused_prot = ^AW_PORT;

    assign AW_READY = (state == IDLE) && !aw_held;
    assign W_READY  = (state == IDLE) && !w_held;
    assign aw_hs    = AW_VALID && AW_READY;
    assign w_hs     = W_VALID && W_READY;

    // The lower-bound test keeps addresses below BASE from wrapping into range.
    assign offset   = aw_addr_q - BASE;
    assign in_range = (aw_addr_q >= BASE) && (offset < SPAN);
    assign index    = offset[3 +: IW];

    assign dbg_data = mem[dbg_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            B_VALID   <= 1'b0;
            B_RESP    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= AW_ADDR;
                        aw_held   <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= W_DATA;
                        w_strb_q <= W_STRB;
                        w_held   <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (in_range) begin
                        for (int unsigned b = 0; b < 8; b++) begin
                            if (w_strb_q[b]) begin
                                mem[index][8*b +: 8] <= w_data_q[8*b +: 8];
                            end
                        end
                    end
                    B_RESP  <= !in_range;
                    B_VALID <= 1'b1;
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                    state   <= RESP;
                end
                RESP: begin
                    if (B_READY) begin
                        B_VALID <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// Bench for axi4_lite_write_slave: directed vector table, hand-written reset
// sequences and randomized writes checked against an array memory model.
module tb_axi4_lite_write_slave;
    localparam int unsigned DEPTH = 32;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [63:0]   AW_ADDR = '0;
    logic          AW_VALID = 1'b0;
    logic [2:0]    AW_PORT = '0;
    logic          AW_READY;
    logic [63:0]   W_DATA = '0;
    logic [7:0]    W_STRB = '0;
    logic          W_VALID = 1'b0;
    logic          W_READY;
    logic          B_RESP;
    logic          B_VALID;
    logic          B_READY = 1'b0;
    logic [IW-1:0] dbg_addr = '0;
    logic [63:0]   dbg_data;

    int errors = 0;
    int checks = 0;
    logic [63:0] model [DEPTH];

    axi4_lite_write_slave #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_PORT(AW_PORT), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // Returns the expected response; applies the write to the model when in range.
    function automatic logic model_write(input logic [63:0] addr, input logic [63:0] data,
                                         input logic [7:0] strb, output int idx);
        idx = -1;
        if (addr < BASE) return 1'b1;
        if (addr - BASE >= 64'(DEPTH) * 64'd8) return 1'b1;
        idx = int'((addr - BASE) / 64'd8);
        for (int b = 0; b < 8; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        return 1'b0;
    endfunction

    task automatic check_all(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = IW'(i);
            #1;
            chk(name, dbg_data, model[i]);
        end
    endtask

    // mode 0: AW+W together, 1: AW then W, 2: W then AW. Starts and ends at a negedge.
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int mode, input int bdelay, output logic resp);
        bit aw_done, w_done, aw_f, w_f;
        int n, idx;
        logic exp_resp;
        exp_resp = model_write(addr, data, strb, idx);
        AW_ADDR = addr; W_DATA = data; W_STRB = strb;
        AW_PORT = 3'($urandom);
        AW_VALID = (mode != 2);
        W_VALID  = (mode != 1);
        B_READY  = (bdelay == 0);
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = AW_VALID && AW_READY;
            w_f  = W_VALID && W_READY;
            @(negedge clk);
            n++;
            if (aw_f) begin aw_done = 1; AW_VALID = 1'b0; end
            if (w_f)  begin w_done = 1;  W_VALID = 1'b0; end
            if (aw_done && !w_done && mode == 1) W_VALID = 1'b1;
            if (w_done && !aw_done && mode == 2) AW_VALID = 1'b1;
        end
        AW_VALID = 1'b0; W_VALID = 1'b0;
        chk("handshake_done", 64'(aw_done && w_done), 64'd1);
        chk("bvalid_before_write", 64'(B_VALID), 64'd0);
        @(negedge clk);
        chk("bvalid_rise", 64'(B_VALID), 64'd1);
        chk("bresp", 64'(B_RESP), 64'(exp_resp));
        resp = B_RESP;
        if (idx >= 0) begin
            dbg_addr = IW'(idx);
            #1;
            chk("dbg_after_write", dbg_data, model[idx]);
        end
        for (int k = 0; k < bdelay; k++) begin
            chk("bvalid_hold", 64'(B_VALID), 64'd1);
            chk("bresp_hold", 64'(B_RESP), 64'(resp));
            chk("ready_low_in_resp", 64'(AW_READY || W_READY), 64'd0);
            @(negedge clk);
        end
        B_READY = 1'b1;
        @(negedge clk);
        chk("bvalid_fall", 64'(B_VALID), 64'd0);
        chk("ready_back", 64'(AW_READY && W_READY), 64'd1);
        B_READY = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        int          mode;
        int          bdelay;
        logic        exp_resp;
        int          exp_idx;
        logic [63:0] exp_word;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic r;
        int idx;
        logic [63:0] addr;
        int sel;

        vecs[0]  = '{64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1, 0, 1'b0, 2,  64'hDEAD_BEEF_0123_4567};
        vecs[1]  = '{64'h8000_0000, 64'h1111_1111_1111_1111, 8'hFF, 0, 0, 1'b0, 0,  64'h1111_1111_1111_1111};
        vecs[2]  = '{64'h8000_0000, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 0, 0, 1'b0, 0,  64'h1111_1111_EEFF_0011};
        vecs[3]  = '{64'h8000_0000, 64'h1111_1111_1111_1111, 8'hFF, 2, 1, 1'b0, 0,  64'h1111_1111_1111_1111};
        vecs[4]  = '{64'h8000_0000, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 2, 0, 1'b0, 0,  64'h1111_1111_EEFF_0011};
        vecs[5]  = '{64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 1'b1, 0,  64'h1111_1111_EEFF_0011};
        vecs[6]  = '{64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 0, 1'b1, 31, 64'h0};
        vecs[7]  = '{64'h8000_00F8, 64'h0123_4567_89AB_CDEF, 8'h81, 0, 5, 1'b0, 31, 64'h0100_0000_0000_00EF};
        vecs[8]  = '{64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, 1'b0, 3,  64'h0};
        vecs[9]  = '{64'h8000_0007, 64'h2222_2222_3333_3333, 8'hF0, 1, 2, 1'b0, 0,  64'h2222_2222_EEFF_0011};
        vecs[10] = '{64'h0,         64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2, 0, 1'b1, 0,  64'h2222_2222_EEFF_0011};

        // Reset with both valids asserted: handshakes must be ignored.
        model_clear();
        AW_VALID = 1'b1; W_VALID = 1'b1; AW_ADDR = BASE; W_DATA = '1; W_STRB = '1;
        #1;
        chk("reset_aw_ready", 64'(AW_READY), 64'd1);
        chk("reset_w_ready", 64'(W_READY), 64'd1);
        chk("reset_bvalid", 64'(B_VALID), 64'd0);
        chk("reset_bresp", 64'(B_RESP), 64'd0);
        repeat (2) @(negedge clk);
        AW_VALID = 1'b0; W_VALID = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_resp_after_reset", 64'(B_VALID), 64'd0);
        end
        check_all("reset_mem");

        foreach (vecs[i]) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode, vecs[i].bdelay, r);
            chk("vec_resp", 64'(r), 64'(vecs[i].exp_resp));
            dbg_addr = IW'(vecs[i].exp_idx);
            #1;
            chk("vec_word", dbg_data, vecs[i].exp_word);
        end
        check_all("vec_mem");

        // Reset after AW only: the held address must be discarded.
        AW_ADDR = 64'h8000_0020; AW_VALID = 1'b1;
        @(negedge clk);
        AW_VALID = 1'b0;
        chk("aw_held_ready", 64'(AW_READY), 64'd0);
        rst = 1'b0;
        #1;
        chk("midreset_bvalid", 64'(B_VALID), 64'd0);
        chk("midreset_aw_ready", 64'(AW_READY), 64'd1);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        W_DATA = 64'h5555_5555_5555_5555; W_STRB = '1; W_VALID = 1'b1;
        @(negedge clk);
        W_VALID = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("w_alone_no_resp", 64'(B_VALID), 64'd0);
        end
        check_all("w_alone_mem");

        // Reset while B_VALID is high: it must drop without a clock edge.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        AW_ADDR = 64'h8000_0008; W_DATA = 64'h7777; W_STRB = '1;
        AW_VALID = 1'b1; W_VALID = 1'b1; B_READY = 1'b0;
        @(negedge clk);
        AW_VALID = 1'b0; W_VALID = 1'b0;
        @(negedge clk);
        chk("pre_reset_bvalid", 64'(B_VALID), 64'd1);
        rst = 1'b0;
        #1;
        chk("reset_drops_bvalid", 64'(B_VALID), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_write(64'h8000_0028, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, r);
        chk("post_reset_resp", 64'(r), 64'd0);
        check_all("post_reset_mem");

        for (int t = 0; t < 60; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       addr = BASE + 64'($urandom_range(0, 8 * DEPTH - 1));
            else if (sel == 8) addr = BASE - 64'($urandom_range(1, 64));
            else               addr = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 1000));
            do_write(addr, {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), r);
        end
        check_all("rand_mem");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
